chan_counter_ovf: RTL and testbench
===================================

CHAN_COUNTER_OVF -- requirements
Module: chan_counter_ovf

Interface
- REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
- REQ-002 Parameter NCH, default 4: number of independent counter channels, legal range 1..16.
- REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
- REQ-004 clk  input  1: clock; all state updates on the rising edge.
- REQ-005 reset  input  1: synchronous, active-high.
- REQ-006 enable  input  NCH: per-channel count enable.
- REQ-007 dir  input  NCH: per-channel direction; 1 = up, 0 = down.
- REQ-008 load  input  NCH: per-channel synchronous load strobe.
- REQ-009 load_value  input  WIDTH: value shared by all channels, used on load.
- REQ-010 clr_ovf  input  NCH: per-channel clear of the sticky flag.
- REQ-011 count_out  output  NCH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-012 ovf_pulse  output  NCH: one-cycle boundary-event strobe per channel.
- REQ-013 ovf_sticky  output  NCH: latched boundary-event flag per channel.
- REQ-014 any_ovf  output  1: OR of all ovf_sticky bits.

Function
- REQ-015 Per-channel priority, evaluated each cycle:
  - reset, then load, then enable, otherwise hold.
- REQ-016 load: the channel takes load_value on the next edge; no boundary event is raised, even if enable is also high.
- REQ-017 Count step: with enable high and load low, the channel steps by +1 (dir=1) or -1 (dir=0) on the next edge.
- REQ-018 Boundary event: enable high, load low, and either dir=1 with count = 2^WIDTH-1 or dir=0 with count = 0.
- REQ-019 Boundary value, SATURATE=0: the count wraps to 0 (up) or to 2^WIDTH-1 (down).
- REQ-020 Boundary value, SATURATE=1: the count holds its current value, and the event is still raised.
- REQ-021 ovf_pulse is registered and asserts in the same cycle that count_out first shows the post-event value.
- REQ-022 ovf_pulse lasts exactly one cycle per event and stays high on consecutive events, for example saturated counting held against the boundary.
- REQ-023 ovf_sticky sets with ovf_pulse and stays set until clr_ovf.
- REQ-024 clr_ovf in the same cycle as a new event: set wins.
- REQ-025 Latency: one cycle from the input edge to count_out; any_ovf is combinational from ovf_sticky.
- REQ-026 Channels are fully independent: no cross-channel interaction except any_ovf.

Reset
- REQ-027 On reset, every count_out channel = 0, ovf_pulse = 0, ovf_sticky = 0, and irq = 0 when present.
- REQ-028 reset overrides load, enable and clr_ovf in the same cycle.
- REQ-029 A reset asserted mid-count leaves no pending pulse after deassertion.

Configuration
- REQ-030 Macro CHAN_COUNTER_OVF_IRQ_EN defined:
  - adds input irq_mask[NCH];
  - adds output irq, registered, equal to the OR over i of (ovf_sticky[i] & irq_mask[i]);
  - irq therefore lags ovf_sticky by one cycle.
- REQ-031 Macro not defined: the irq_mask and irq ports and their logic are absent; all other behaviour is identical.

Structure
- REQ-032 Package chan_counter_pkg holds the default WIDTH/NCH/SATURATE constants and the direction encodings DIR_UP=1 and DIR_DOWN=0.
- REQ-033 Sub-module chan_counter_lane implements one channel (count, pulse, sticky).
- REQ-034 The top level instantiates chan_counter_lane NCH times via generate and adds any_ovf and irq.

Verification (WIDTH=4, NCH=2, unless stated)
- REQ-035 Reset, then enable[0] up for 16 cycles:
  - ch0 counts 1..15, then 0;
  - ovf_pulse[0] is high for one cycle with count=0;
  - ovf_sticky[0] and any_ovf = 1; ch1 stays 0.
- REQ-036 SATURATE=1, ch0 at 15, enable up for 3 cycles:
  - count holds 15;
  - ovf_pulse[0] is high in all 3 cycles.
- REQ-037 Down-count from 0 with SATURATE=0:
  - next count = 15, ovf_pulse = 1;
  - then load=1 with load_value=7 and enable=1 gives count = 7 and no pulse.
- REQ-038 Sticky set, then clr_ovf in the same cycle as a new event: sticky stays 1; clr_ovf alone next cycle: sticky = 0.
- REQ-039 reset asserted at count=9 in the same cycle as load=1: count = 0 and all flags = 0.
- REQ-040 With CHAN_COUNTER_OVF_IRQ_EN:
  - irq_mask=01 and an event on ch1 only: irq stays 0;
  - an event on ch0: irq = 1 one cycle after ovf_sticky[0].

Source files
------------

// File: rtl/chan_counter_pkg.sv
// chan_counter_pkg: shared defaults and direction encoding for the channel counter.
// Contents: DEF_WIDTH, DEF_NCH, DEF_SATURATE defaults; dir_t with DIR_UP=1, DIR_DOWN=0.
package chan_counter_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NCH      = 4;
    localparam bit DEF_SATURATE = 1'b0;
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;
endpackage

// File: rtl/chan_counter_lane.sv
// chan_counter_lane: one up/down counter channel with boundary pulse and sticky flag.
// Ports: clk, reset (sync, active-high); enable, dir, load, load_value, clr_ovf in;
//        count (current value), pulse (one-cycle boundary strobe), sticky (latched event) out.
module chan_counter_lane
    import chan_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             pulse,
    output logic             sticky
);
    logic             step;
    logic             hit;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] next_count;

    // load masks counting, so a load never raises a boundary event
    assign step       = enable & ~load;
    assign hit        = step & ((dir == DIR_UP) ? (count == '1) : (count == '0));
    // plain modular arithmetic gives the wrap values for free
    assign stepped    = (dir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    assign next_count = load ? load_value :
                        !step ? count :
                        (hit && SATURATE) ? count : stepped;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            pulse  <= 1'b0;
            sticky <= 1'b0;
        end else begin
            count  <= next_count;
            pulse  <= hit;
            // a new event wins over a simultaneous clear
            sticky <= hit | (sticky & ~clr_ovf);
        end
    end
endmodule

// File: rtl/chan_counter_ovf.sv
// chan_counter_ovf: NCH independent up/down counters with per-channel boundary pulse/sticky flags.
// Ports: clk, reset (sync, active-high); enable/dir/load/clr_ovf [NCH], load_value [WIDTH] in;
//        count_out [NCH*WIDTH] (channel i at [i*WIDTH +: WIDTH]), ovf_pulse/ovf_sticky [NCH],
//        any_ovf (OR of sticky flags) out.
// Option CHAN_COUNTER_OVF_IRQ_EN: adds irq_mask [NCH] in and registered irq out.
module chan_counter_ovf
    import chan_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NCH      = DEF_NCH,
    parameter bit SATURATE = DEF_SATURATE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       load,
    input  logic [WIDTH-1:0]     load_value,
    input  logic [NCH-1:0]       clr_ovf,
`ifdef CHAN_COUNTER_OVF_IRQ_EN
    input  logic [NCH-1:0]       irq_mask,
    output logic                 irq,
`endif
    output logic [NCH*WIDTH-1:0] count_out,
    output logic [NCH-1:0]       ovf_pulse,
    output logic [NCH-1:0]       ovf_sticky,
    output logic                 any_ovf
);
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        chan_counter_lane #(
            .WIDTH   (WIDTH),
            .SATURATE(SATURATE)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable[i]),
            .dir       (dir[i]),
            .load      (load[i]),
            .load_value(load_value),
            .clr_ovf   (clr_ovf[i]),
            .count     (count_out[i*WIDTH +: WIDTH]),
            .pulse     (ovf_pulse[i]),
            .sticky    (ovf_sticky[i])
        );
    end

    assign any_ovf = |ovf_sticky;

`ifdef CHAN_COUNTER_OVF_IRQ_EN
    // registered from the sticky flags, so irq trails ovf_sticky by one cycle
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(ovf_sticky & irq_mask);
    end
`endif
endmodule

// File: tb/tb_chan_counter_ovf.sv
// tb_chan_counter_ovf: randomized and directed checks of chan_counter_ovf (wrap and saturate builds).
module tb_chan_counter_ovf;
    localparam int W    = 4;
    localparam int N    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   enable, dir, load, clr_ovf;
    logic [W-1:0]   load_value;
    logic [N*W-1:0] count_w, count_s;
    logic [N-1:0]   pulse_w, pulse_s, sticky_w, sticky_s;
    logic           any_w, any_s;
`ifdef CHAN_COUNTER_OVF_IRQ_EN
    logic [N-1:0]   irq_mask;
    logic           irq_w, irq_s;
    bit             m_irq[2];
`endif

    int total  = 0;
    int passed = 0;

    // reference state: index 0 = wrapping build, 1 = saturating build
    int m_cnt[2][N];
    bit m_pulse[2][N];
    bit m_sticky[2][N];

    always #5 clk = ~clk;

    chan_counter_ovf #(.WIDTH(W), .NCH(N), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
        .load_value(load_value), .clr_ovf(clr_ovf),
`ifdef CHAN_COUNTER_OVF_IRQ_EN
        .irq_mask(irq_mask), .irq(irq_w),
`endif
        .count_out(count_w), .ovf_pulse(pulse_w), .ovf_sticky(sticky_w), .any_ovf(any_w)
    );

    chan_counter_ovf #(.WIDTH(W), .NCH(N), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
        .load_value(load_value), .clr_ovf(clr_ovf),
`ifdef CHAN_COUNTER_OVF_IRQ_EN
        .irq_mask(irq_mask), .irq(irq_s),
`endif
        .count_out(count_s), .ovf_pulse(pulse_s), .ovf_sticky(sticky_s), .any_ovf(any_s)
    );

    // Behavioural model: count as an integer, detect leaving the range 0..MAXV.
    function automatic void model_step();
        int  nxt;
        bit  ev;
        for (int s = 0; s < 2; s++) begin
`ifdef CHAN_COUNTER_OVF_IRQ_EN
            bit masked = 1'b0;
            for (int i = 0; i < N; i++) masked |= m_sticky[s][i] & irq_mask[i];
            m_irq[s] = reset ? 1'b0 : masked;
`endif
            for (int i = 0; i < N; i++) begin
                if (reset) begin
                    m_cnt[s][i] = 0; m_pulse[s][i] = 0; m_sticky[s][i] = 0;
                end else if (load[i]) begin
                    m_cnt[s][i] = int'(load_value);
                    m_pulse[s][i] = 0;
                    m_sticky[s][i] = m_sticky[s][i] & !clr_ovf[i];
                end else if (enable[i]) begin
                    nxt = dir[i] ? m_cnt[s][i] + 1 : m_cnt[s][i] - 1;
                    ev  = (nxt < 0) || (nxt > MAXV);
                    if (ev) nxt = (s == 1) ? m_cnt[s][i] : (nxt + MAXV + 1) % (MAXV + 1);
                    m_cnt[s][i] = nxt;
                    m_pulse[s][i] = ev;
                    m_sticky[s][i] = ev | (m_sticky[s][i] & !clr_ovf[i]);
                end else begin
                    m_pulse[s][i] = 0;
                    m_sticky[s][i] = m_sticky[s][i] & !clr_ovf[i];
                end
            end
        end
    endfunction

    function automatic logic [N*W-1:0] e_cnt(int s);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_cnt[s][i]);
        return r;
    endfunction

    function automatic logic [N-1:0] e_pulse(int s);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_pulse[s][i];
        return r;
    endfunction

    function automatic logic [N-1:0] e_sticky(int s);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_sticky[s][i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; enable = '0; dir = '0; load = '0; clr_ovf = '0; load_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; load = '1; enable = '1; dir = '1; load_value = 4'd5; clr_ovf = '0;
        tick();
        tick();
        total++; if (count_w !== '0) $display("FAIL reset_count got=%h exp=0", count_w); else passed++;
        total++; if (count_s !== '0) $display("FAIL reset_count_sat got=%h exp=0", count_s); else passed++;
        total++; if (pulse_w !== '0 || pulse_s !== '0) $display("FAIL reset_pulse got=%b/%b exp=0", pulse_w, pulse_s); else passed++;
        total++; if (sticky_w !== '0 || sticky_s !== '0) $display("FAIL reset_sticky got=%b/%b exp=0", sticky_w, sticky_s); else passed++;
        total++; if (any_w !== 1'b0 || any_s !== 1'b0) $display("FAIL reset_any got=%b/%b exp=0", any_w, any_s); else passed++;
`ifdef CHAN_COUNTER_OVF_IRQ_EN
        total++; if (irq_w !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq_w); else passed++;
`endif
        reset = 0;
    endtask

    task automatic test_wrap_up();
        do_reset();
        enable = 2'b01; dir = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++; if (count_w[W-1:0] !== W'(k % 16)) $display("FAIL wrap_up_count k=%0d got=%0d exp=%0d", k, count_w[W-1:0], k % 16); else passed++;
            total++; if (pulse_w !== ((k == 16) ? 2'b01 : 2'b00)) $display("FAIL wrap_up_pulse k=%0d got=%b exp=%b", k, pulse_w, (k == 16) ? 2'b01 : 2'b00); else passed++;
        end
        total++; if (sticky_w !== 2'b01) $display("FAIL wrap_up_sticky got=%b exp=01", sticky_w); else passed++;
        total++; if (any_w !== 1'b1) $display("FAIL wrap_up_any got=%b exp=1", any_w); else passed++;
        total++; if (count_w[2*W-1:W] !== '0) $display("FAIL wrap_up_ch1 got=%0d exp=0", count_w[2*W-1:W]); else passed++;
        enable = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        load = 2'b01; load_value = 4'd15;
        tick();
        load = '0; enable = 2'b01; dir = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (count_s[W-1:0] !== 4'd15) $display("FAIL sat_count k=%0d got=%0d exp=15", k, count_s[W-1:0]); else passed++;
            total++; if (pulse_s[0] !== 1'b1) $display("FAIL sat_pulse k=%0d got=%b exp=1", k, pulse_s[0]); else passed++;
            total++; if (count_w !== e_cnt(0)) $display("FAIL sat_wrap_side k=%0d got=%h exp=%h", k, count_w, e_cnt(0)); else passed++;
        end
        enable = '0;
    endtask

    task automatic test_down_load();
        do_reset();
        enable = 2'b01; dir = 2'b00;
        tick();
        total++; if (count_w[W-1:0] !== 4'd15) $display("FAIL down_wrap_count got=%0d exp=15", count_w[W-1:0]); else passed++;
        total++; if (pulse_w[0] !== 1'b1) $display("FAIL down_wrap_pulse got=%b exp=1", pulse_w[0]); else passed++;
        total++; if (count_s[W-1:0] !== 4'd0 || pulse_s[0] !== 1'b1) $display("FAIL down_sat got=%0d/%b exp=0/1", count_s[W-1:0], pulse_s[0]); else passed++;
        load = 2'b01; load_value = 4'd7;
        tick();
        total++; if (count_w[W-1:0] !== 4'd7) $display("FAIL load_count got=%0d exp=7", count_w[W-1:0]); else passed++;
        total++; if (pulse_w[0] !== 1'b0) $display("FAIL load_no_pulse got=%b exp=0", pulse_w[0]); else passed++;
        load = '0; enable = '0;
    endtask

    task automatic test_clr_collision();
        do_reset();
        load = 2'b01; load_value = 4'd15;
        tick();
        load = '0; enable = 2'b01; dir = 2'b11;
        tick();
        total++; if (sticky_s[0] !== 1'b1) $display("FAIL clr_setup_sticky got=%b exp=1", sticky_s[0]); else passed++;
        clr_ovf = 2'b01;
        tick();
        total++; if (sticky_s[0] !== 1'b1) $display("FAIL clr_collision_sticky got=%b exp=1", sticky_s[0]); else passed++;
        total++; if (sticky_w !== e_sticky(0)) $display("FAIL clr_collision_wrap got=%b exp=%b", sticky_w, e_sticky(0)); else passed++;
        enable = '0;
        tick();
        total++; if (sticky_s[0] !== 1'b0) $display("FAIL clr_alone_sticky got=%b exp=0", sticky_s[0]); else passed++;
        total++; if (any_s !== 1'b0) $display("FAIL clr_alone_any got=%b exp=0", any_s); else passed++;
        clr_ovf = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load = 2'b01; load_value = 4'd9;
        tick();
        total++; if (count_w[W-1:0] !== 4'd9) $display("FAIL mid_load9 got=%0d exp=9", count_w[W-1:0]); else passed++;
        reset = 1; load = 2'b01; enable = 2'b11; load_value = 4'd3;
        tick();
        total++; if (count_w !== '0 || pulse_w !== '0 || sticky_w !== '0) $display("FAIL mid_reset got=%h/%b/%b exp=0/0/0", count_w, pulse_w, sticky_w); else passed++;
        reset = 0; enable = '0; load = 2'b01; load_value = 4'd15;
        tick();
        load = '0; enable = 2'b01; dir = 2'b11; reset = 1;
        tick();
        reset = 0; enable = '0;
        tick();
        total++; if (pulse_w !== '0 || pulse_s !== '0) $display("FAIL mid_no_pending got=%b/%b exp=0", pulse_w, pulse_s); else passed++;
        total++; if (sticky_w !== '0 || sticky_s !== '0) $display("FAIL mid_no_sticky got=%b/%b exp=0", sticky_w, sticky_s); else passed++;
    endtask

`ifdef CHAN_COUNTER_OVF_IRQ_EN
    task automatic test_irq();
        do_reset();
        irq_mask = 2'b01;
        load = 2'b10; load_value = 4'd15;
        tick();
        load = '0; enable = 2'b10; dir = 2'b11;
        tick();
        enable = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (irq_w !== 1'b0) $display("FAIL irq_masked k=%0d got=%b exp=0", k, irq_w); else passed++;
        end
        load = 2'b01;
        tick();
        load = '0; enable = 2'b01;
        tick();
        total++; if (sticky_w[0] !== 1'b1 || irq_w !== 1'b0) $display("FAIL irq_lag got=%b/%b exp=1/0", sticky_w[0], irq_w); else passed++;
        enable = '0;
        tick();
        total++; if (irq_w !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq_w); else passed++;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 31) == 0);
            enable     = N'($urandom);
            dir        = N'($urandom);
            load       = N'($urandom) & N'($urandom) & N'($urandom);
            clr_ovf    = N'($urandom) & N'($urandom);
            load_value = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 4'd15 : 4'd0) : W'($urandom);
`ifdef CHAN_COUNTER_OVF_IRQ_EN
            irq_mask   = N'($urandom);
`endif
            tick();
            total++;
            if ({count_w, pulse_w, sticky_w, any_w} !== {e_cnt(0), e_pulse(0), e_sticky(0), |e_sticky(0)})
                $display("FAIL rand_wrap k=%0d got=%h/%b/%b/%b exp=%h/%b/%b", k, count_w, pulse_w, sticky_w, any_w, e_cnt(0), e_pulse(0), e_sticky(0));
            else passed++;
            total++;
            if ({count_s, pulse_s, sticky_s, any_s} !== {e_cnt(1), e_pulse(1), e_sticky(1), |e_sticky(1)})
                $display("FAIL rand_sat k=%0d got=%h/%b/%b/%b exp=%h/%b/%b", k, count_s, pulse_s, sticky_s, any_s, e_cnt(1), e_pulse(1), e_sticky(1));
            else passed++;
`ifdef CHAN_COUNTER_OVF_IRQ_EN
            total++;
            if ({irq_w, irq_s} !== {m_irq[0], m_irq[1]}) $display("FAIL rand_irq k=%0d got=%b%b exp=%b%b", k, irq_w, irq_s, m_irq[0], m_irq[1]);
            else passed++;
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
`ifdef CHAN_COUNTER_OVF_IRQ_EN
        irq_mask = '0;
`endif
        test_reset();
        test_wrap_up();
        test_saturate();
        test_down_load();
        test_clr_collision();
        test_reset_mid();
`ifdef CHAN_COUNTER_OVF_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
